instr_trace_buffer: RTL and testbench

//  Synthesisable instruction trace capture for the processor core. Hardware successor to the

---
 rtl/instr_trace_buffer.sv | 140 ++++++++++++++
 tb/tb_instr_trace_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_trace_buffer.sv
// Instruction trace capture: circular buffer of {ts, pc, instr} frozen by an
// immediate or masked-match trigger, read back oldest-first.
module instr_trace_buffer #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 16,
  parameter int TS_WIDTH    = 16,
  parameter int DEPTH       = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = TS_WIDTH + PC_WIDTH + INSTR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   instr_valid,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   arm,
  input  logic                   trig_mode,
  input  logic [INSTR_WIDTH-1:0] trig_value,
  input  logic [INSTR_WIDTH-1:0] trig_mask,
  input  logic [AW-1:0]          post_count,
  input  logic [AW-1:0]          rd_addr,
  output logic [EW-1:0]          rd_data,
  output logic [1:0]             state,
  output logic                   done,
  output logic [AW:0]            entry_count,
  output logic [AW-1:0]          trig_index
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } st_t;

  st_t state_q, state_d;

  logic [EW-1:0]          mem [DEPTH];
  logic [TS_WIDTH-1:0]    ts_q;
  logic [AW-1:0]          wr_ptr_q;
  logic [AW:0]            count_q;
  logic [AW-1:0]          remaining_q;
  logic                   pending_q;
  logic [AW-1:0]          post_q;
  logic [INSTR_WIDTH-1:0] value_q;
  logic [INSTR_WIDTH-1:0] mask_q;
  logic [AW-1:0]          tidx_q;

  logic          capturing;
  logic          wr_en;
  logic          match;
  logic [AW:0]   count_inc;
  logic [AW:0]   tidx_full;
  logic [AW-1:0] start;
  logic [AW-1:0] phys;
  logic          rd_hit;

  assign capturing = (state_q == S_PRE) || (state_q == S_POST);
  assign wr_en     = capturing && instr_valid && !arm;
  assign match     = (state_q == S_PRE) && instr_valid &&
                     (((instruction ^ value_q) & mask_q) == '0);
  assign count_inc = (count_q == (AW+1)'(DEPTH)) ? count_q : count_q + (AW+1)'(1);
  assign tidx_full = count_inc - (AW+1)'(1) - {1'b0, post_q};
  assign start     = (count_q == (AW+1)'(DEPTH)) ? wr_ptr_q : '0;
  assign phys      = start + rd_addr;
  assign rd_hit    = (state_q == S_DONE) && ({1'b0, rd_addr} < count_q);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // In immediate mode the trigger entry is the first POST write; pending
  // marks it so it does not consume one of the post_count slots.
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = trig_mode ? S_PRE : S_POST;
    end else begin
      case (state_q)
        S_PRE:  if (match) state_d = (post_q == '0) ? S_DONE : S_POST;
        S_POST: if (instr_valid) begin
                  if (pending_q ? (remaining_q == '0) : (remaining_q == AW'(1)))
                    state_d = S_DONE;
                end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    state       = state_q;
    done        = (state_q == S_DONE);
    entry_count = count_q;
    trig_index  = tidx_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      pending_q   <= 1'b0;
      post_q      <= '0;
      value_q     <= '0;
      mask_q      <= '0;
      tidx_q      <= '0;
      rd_data     <= '0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
      if (arm) begin
        wr_ptr_q    <= '0;
        count_q     <= '0;
        post_q      <= post_count;
        value_q     <= trig_value;
        mask_q      <= trig_mask;
        remaining_q <= post_count;
        pending_q   <= !trig_mode;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        count_q  <= count_inc;
        if (match) begin
          remaining_q <= post_q;
        end else if (state_q == S_POST) begin
          if (pending_q) pending_q   <= 1'b0;
          else           remaining_q <= remaining_q - AW'(1);
        end
      end
      if (state_q != S_DONE && state_d == S_DONE)
        tidx_q <= tidx_full[AW-1:0];
      rd_data <= rd_hit ? mem[phys] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= {ts_q, pc, instruction};
  end

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed self-checking bench for instr_trace_buffer.
module tb_instr_trace_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [15:0] pc;
  logic        arm;
  logic        trig_mode;
  logic [31:0] trig_value;
  logic [31:0] trig_mask;
  logic [3:0]  post_count;
  logic [3:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  state;
  logic        done;
  logic [4:0]  entry_count;
  logic [3:0]  trig_index;

  int checks = 0;
  int errors = 0;

  instr_trace_buffer #(
    .INSTR_WIDTH(32),
    .PC_WIDTH   (16),
    .TS_WIDTH   (16),
    .DEPTH      (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instruction(instruction),
    .pc         (pc),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .post_count (post_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .state      (state),
    .done       (done),
    .entry_count(entry_count),
    .trig_index (trig_index)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic vld(input logic [31:0] i, input logic [15:0] p);
    instr_valid = 1'b1;
    instruction = i;
    pc          = p;
    tick;
    instr_valid = 1'b0;
  endtask

  task automatic do_arm(input logic m, input logic [31:0] v, input logic [31:0] k,
                        input logic [3:0] pcnt);
    arm        = 1'b1;
    trig_mode  = m;
    trig_value = v;
    trig_mask  = k;
    post_count = pcnt;
    tick;
    arm = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_addr = a;
    tick;
  endtask

  function automatic logic [31:0] instr_of(input int n);
    logic [7:0] nb;
    nb = n[7:0];
    return {8'h5A, 8'h00, nb, (n == 17) ? 8'h13 : 8'h00};
  endfunction

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instruction = '0; pc = '0; arm = 1'b0;
    trig_mode = 1'b0; trig_value = '0; trig_mask = '0; post_count = '0; rd_addr = '0;
    tick; tick;
    reset = 1'b0;
    check("rst_state", 64'(state), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(entry_count), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_trig_index", 64'(trig_index), 64'd0);

    // timestamps and gaps: writes at ts=5 and ts=8
    do_arm(1'b0, '0, '0, 4'd1);
    check("gap_arm_state", 64'(state), 64'd2);
    tick; tick; tick; tick;
    vld(32'h1111_0001, 16'h0010);
    tick; tick;
    vld(32'h1111_0002, 16'h0014);
    check("gap_done", 64'(done), 64'd1);
    check("gap_count", 64'(entry_count), 64'd2);
    vld(32'h2222_0001, 16'h0020);
    vld(32'h2222_0002, 16'h0024);
    check("done_no_write", 64'(entry_count), 64'd2);
    rd(4'd0);
    check("gap_ts0", 64'(rd_data[63:48]), 64'd5);
    check("gap_e0", 64'(rd_data[47:0]), {16'd0, 16'h0010, 32'h1111_0001});
    rd(4'd1);
    check("gap_ts1", 64'(rd_data[63:48]), 64'd8);

    // immediate trigger, post_count=3
    do_arm(1'b0, '0, '0, 4'd3);
    check("imm_arm_count", 64'(entry_count), 64'd0);
    vld(32'hA000_000A, 16'h0100);
    check("imm_after_a", 64'(state), 64'd2);
    vld(32'hA000_000B, 16'h0104);
    vld(32'hA000_000C, 16'h0108);
    check("imm_before_d", 64'(state), 64'd2);
    vld(32'hA000_000D, 16'h010C);
    check("imm_done", 64'(state), 64'd3);
    vld(32'hA000_000E, 16'h0110);
    check("imm_count", 64'(entry_count), 64'd4);
    check("imm_trig_index", 64'(trig_index), 64'd0);
    rd(4'd0); check("imm_rd0", 64'(rd_data[47:0]), {16'd0, 16'h0100, 32'hA000_000A});
    rd(4'd1); check("imm_rd1", 64'(rd_data[47:0]), {16'd0, 16'h0104, 32'hA000_000B});
    rd(4'd2); check("imm_rd2", 64'(rd_data[47:0]), {16'd0, 16'h0108, 32'hA000_000C});
    rd(4'd3); check("imm_rd3", 64'(rd_data[47:0]), {16'd0, 16'h010C, 32'hA000_000D});
    rd(4'd4); check("imm_rd4_zero", rd_data, 64'd0);

    // masked match with wrap
    do_arm(1'b1, 32'h13, 32'hFF, 4'd2);
    check("wrap_arm_state", 64'(state), 64'd1);
    for (int n = 1; n <= 20; n++) begin
      vld(instr_of(n), 16'(16'h1000 + n));
      if (n == 16) check("wrap_pre16", 64'(state), 64'd1);
      if (n == 17) check("wrap_post17", 64'(state), 64'd2);
      if (n == 18) check("wrap_post18", 64'(state), 64'd2);
      if (n == 19) check("wrap_done19", 64'(state), 64'd3);
    end
    check("wrap_count", 64'(entry_count), 64'd16);
    check("wrap_trig_index", 64'(trig_index), 64'd13);
    rd(4'd0);  check("wrap_rd0", 64'(rd_data[47:0]), {16'd0, 16'h1004, instr_of(4)});
    rd(4'd13); check("wrap_rd13", 64'(rd_data[47:0]), {16'd0, 16'h1011, instr_of(17)});
    rd(4'd15); check("wrap_rd15", 64'(rd_data[47:0]), {16'd0, 16'h1013, instr_of(19)});

    // match with post_count=0
    do_arm(1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 4'd0);
    vld(32'h0000_0001, 16'h0200);
    vld(32'h0000_0002, 16'h0204);
    check("p0_pre", 64'(state), 64'd1);
    vld(32'hDEAD_BEEF, 16'h0208);
    check("p0_done", 64'(state), 64'd3);
    check("p0_count", 64'(entry_count), 64'd3);
    check("p0_trig_index", 64'(trig_index), 64'd2);
    rd(4'd2); check("p0_rd2", 64'(rd_data[47:0]), {16'd0, 16'h0208, 32'hDEAD_BEEF});

    // re-arm mid-POST, then reset mid-PRE
    do_arm(1'b1, 32'h0000_00AA, 32'hFF, 4'd2);
    vld(32'h0000_00AA, 16'h0300);
    check("rearm_post", 64'(state), 64'd2);
    do_arm(1'b1, 32'h0000_00AA, 32'hFF, 4'd2);
    check("rearm_state", 64'(state), 64'd1);
    check("rearm_count", 64'(entry_count), 64'd0);
    vld(32'h0000_0001, 16'h0304);
    vld(32'h0000_0002, 16'h0308);
    check("pre_count", 64'(entry_count), 64'd2);
    rd(4'd0); check("pre_rd_zero", rd_data, 64'd0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("reset_mid_state", 64'(state), 64'd0);
    check("reset_mid_count", 64'(entry_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
